// File: rtl/alarma_zonas_param.sv
// N-zone alarm controller: entry delay, self-rearming timed silence, latched zone
// reporting and a 4-digit multiplexed 7-segment driver on an 11-bit {an,seg} bus.
module alarma_zonas_param #(
  parameter int N_SENS    = 4,
  parameter int DELAY_CYC = 8,
  parameter int SIL_CYC   = 16,
  parameter int SCAN_DIV  = 4
) (
  input  logic              CLK_ulong,
  input  logic              reset,
  input  logic              armar,
  input  logic              silenciar,
  input  logic [N_SENS-1:0] sensores,
  input  logic [N_SENS-1:0] mascara,
  output logic [2:0]        leds,
  output logic              sirena,
  output logic [N_SENS-1:0] zona_lat,
  output logic [10:0]       SSD
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    PENDING  = 3'd2,
    ALARM    = 3'd3,
    SILENCED = 3'd4
  } state_t;

  localparam logic [15:0] DELAY_LOAD = 16'(DELAY_CYC - 1);
  localparam logic [15:0] SIL_LOAD   = 16'(SIL_CYC - 1);
  localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = SEG_BLANK;
    endcase
  endfunction

  // Scanning downwards lets the lowest set bit win.
  function automatic logic [3:0] lowest_set(input logic [N_SENS-1:0] z);
    logic [3:0] r;
    r = 4'd0;
    for (int i = N_SENS - 1; i >= 0; i--) begin
      if (z[i]) r = 4'(i);
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              sirena_q, sirena_d;
  logic [N_SENS-1:0] zona_q, zona_d;
  logic [N_SENS-1:0] s_meta_q, s_meta_d, s_sync_q, s_sync_d;
  logic [15:0]       div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [10:0]       ssd_q, ssd_d;
  logic [N_SENS-1:0] act_s;
  logic              cnt_zero_s;
  logic [6:0]        seg_s;
  logic [3:0]        an_s;

  assign act_s      = s_sync_q & ~mascara;
  assign cnt_zero_s = (cnt_q == 16'd0);

  // State register plus every datapath flop, all cleared by the async reset.
  always_ff @(posedge CLK_ulong or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      sirena_q <= 1'b0;
      zona_q   <= '0;
      s_meta_q <= '0;
      s_sync_q <= '0;
      div_q    <= 16'd0;
      idx_q    <= 2'd0;
      ssd_q    <= 11'h7FF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sirena_q <= sirena_d;
      zona_q   <= zona_d;
      s_meta_q <= s_meta_d;
      s_sync_q <= s_sync_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      ssd_q    <= ssd_d;
    end
  end

  // Next-state logic; disarm beats every other event.
  always_comb begin
    state_d = state_q;
    if ((state_q != IDLE) && !armar) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = armar ? ARMED : IDLE;
        ARMED:    state_d = (|act_s) ? PENDING : ARMED;
        PENDING:  state_d = cnt_zero_s ? ALARM : PENDING;
        ALARM:    state_d = silenciar ? SILENCED : ALARM;
        SILENCED: begin
          if (cnt_zero_s) begin
            state_d = (|act_s) ? ALARM : ARMED;
          end else begin
            state_d = SILENCED;
          end
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  // Counter, siren and zone latch, keyed on the transition being taken.
  always_comb begin
    cnt_d    = cnt_q;
    zona_d   = zona_q;
    sirena_d = sirena_q;
    s_meta_d = sensores;
    s_sync_d = s_meta_q;
    if (state_d == IDLE) begin
      cnt_d    = 16'd0;
      zona_d   = '0;
      sirena_d = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (state_d == PENDING) begin
            zona_d = zona_q | act_s;
            cnt_d  = DELAY_LOAD;
          end else begin
            zona_d = zona_q;
          end
        end
        PENDING: begin
          zona_d = zona_q | act_s;
          if (!cnt_zero_s) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            sirena_d = 1'b1;
          end
        end
        ALARM: begin
          zona_d = zona_q | act_s;
          if (state_d == SILENCED) begin
            cnt_d    = SIL_LOAD;
            sirena_d = 1'b0;
          end else begin
            sirena_d = 1'b1;
          end
        end
        SILENCED: begin
          zona_d = zona_q | act_s;
          if (!cnt_zero_s) begin
            cnt_d = cnt_q - 16'd1;
          end else if (state_d == ALARM) begin
            sirena_d = 1'b1;
          end else begin
            zona_d = '0;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Digit scanner: divider, digit index and the digit contents.
  always_comb begin
    if (div_q == DIV_LAST) begin
      div_d = 16'd0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + 16'd1;
      idx_d = idx_q;
    end
    case (idx_q)
      2'd0: begin
        an_s  = 4'b1110;
        seg_s = (zona_q == '0) ? SEG_BLANK : hex7(lowest_set(zona_q));
      end
      2'd1: begin
        an_s  = 4'b1101;
        seg_s = hex7({1'b0, state_q});
      end
      2'd2: begin
        an_s  = 4'b1011;
        seg_s = ((state_q == PENDING) || (state_q == SILENCED)) ? hex7(cnt_q[3:0]) : SEG_BLANK;
      end
      2'd3: begin
        an_s  = 4'b0111;
        seg_s = ((state_q == PENDING) || (state_q == SILENCED)) ? hex7(cnt_q[7:4]) : SEG_BLANK;
      end
      default: begin
        an_s  = 4'b1111;
        seg_s = SEG_BLANK;
      end
    endcase
    ssd_d = {an_s, seg_s};
  end

  assign leds     = state_q;
  assign sirena   = sirena_q;
  assign zona_lat = zona_q;
  assign SSD      = ssd_q;

endmodule

// File: tb/tb_alarma_zonas_param.sv
// Bench for alarma_zonas_param: directed scenarios plus a randomized run checked
// against a deadline-based behavioural model of the alarm and its display.
module tb_alarma_zonas_param;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int S  = 16;
  localparam int SD = 4;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic         clk = 1'b0;
  logic         reset, armar, silenciar;
  logic [N-1:0] sensores, mascara;
  logic [2:0]   leds;
  logic         sirena;
  logic [N-1:0] zona_lat;
  logic [10:0]  SSD;

  int checks = 0;
  int errors = 0;

  // Model: state code, edge count since reset, and the edge at which the
  // running delay/silence counter reads zero.
  int           m_st, m_cyc, m_dl;
  logic [N-1:0] m_lat, m_h1, m_h2;
  logic         m_sir;
  logic [10:0]  m_ssd;

  alarma_zonas_param #(.N_SENS(N), .DELAY_CYC(D), .SIL_CYC(S), .SCAN_DIV(SD)) dut (
    .CLK_ulong(clk), .reset(reset), .armar(armar), .silenciar(silenciar),
    .sensores(sensores), .mascara(mascara), .leds(leds), .sirena(sirena),
    .zona_lat(zona_lat), .SSD(SSD)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [N-1:0] z);
    for (int i = 0; i < N; i++) if (z[i]) return i;
    return 0;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_cyc = 0; m_dl = 0; m_lat = '0; m_h1 = '0; m_h2 = '0; m_sir = 1'b0;
    m_ssd = 11'h7FF;
  endfunction

  function automatic void model_update();
    int now, d, rem;
    logic [N-1:0] act;
    logic [6:0] seg;
    logic [3:0] oh;
    now = m_cyc;
    act = m_h2 & ~mascara;
    rem = m_dl - now;
    d = (now / SD) % 4;
    case (d)
      0: seg = (m_lat == '0) ? 7'h7F : HEX[lowest(m_lat)];
      1: seg = HEX[m_st];
      2: seg = (m_st == 2 || m_st == 4) ? HEX[rem % 16] : 7'h7F;
      default: seg = (m_st == 2 || m_st == 4) ? HEX[(rem / 16) % 16] : 7'h7F;
    endcase
    oh = 4'b0001 << d;
    m_ssd = {~oh, seg};
    if (m_st != 0 && !armar) begin
      m_st = 0; m_lat = '0; m_sir = 1'b0;
    end else begin
      case (m_st)
        0: if (armar) m_st = 1;
        1: if (act != '0) begin m_st = 2; m_lat |= act; m_dl = now + D; end
        2: begin
          m_lat |= act;
          if (now == m_dl) begin m_st = 3; m_sir = 1'b1; end
        end
        3: begin
          m_lat |= act;
          if (silenciar) begin m_st = 4; m_sir = 1'b0; m_dl = now + S; end
        end
        4: begin
          m_lat |= act;
          if (now == m_dl) begin
            if (act != '0) begin m_st = 3; m_sir = 1'b1; end
            else begin m_st = 1; m_lat = '0; end
          end
        end
        default: m_st = 0;
      endcase
    end
    m_h2 = m_h1;
    m_h1 = sensores;
    m_cyc++;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; armar = 1'b0; silenciar = 1'b0; sensores = '0; mascara = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (leds !== 3'd0) begin errors++; $display("FAIL rst_leds: got %0d expected 0", leds); end
    checks++; if (sirena !== 1'b0) begin errors++; $display("FAIL rst_sirena: got %b expected 0", sirena); end
    checks++; if (zona_lat !== 4'b0000) begin errors++; $display("FAIL rst_zona: got %b expected 0000", zona_lat); end
    reset = 1'b0;
    model_reset();
    checks++; if (SSD !== 11'h7FF) begin errors++; $display("FAIL rst_ssd: got %h expected 7ff", SSD); end
  endtask

  task automatic test_scan();
    logic [3:0] oh;
    for (int t = 1; t <= 16; t++) begin
      tick();
      oh = 4'b0001 << (((t - 1) / SD) % 4);
      checks++; if (SSD[10:7] !== ~oh) begin errors++; $display("FAIL scan_an t=%0d: got %b expected %b", t, SSD[10:7], ~oh); end
      checks++; if (SSD !== m_ssd) begin errors++; $display("FAIL scan_ssd t=%0d: got %h expected %h", t, SSD, m_ssd); end
      if (t == 5) begin
        checks++; if (SSD !== {4'b1101, 7'h40}) begin errors++; $display("FAIL scan_digit1: got %h expected %h", SSD, {4'b1101, 7'h40}); end
      end
    end
  endtask

  task automatic test_entry_delay();
    armar = 1'b1;
    tick();
    checks++; if (leds !== 3'd1) begin errors++; $display("FAIL arm_leds: got %0d expected 1", leds); end
    sensores = 4'b0100;
    ticks(2);
    checks++; if (leds !== 3'd1) begin errors++; $display("FAIL sync_latency: got %0d expected 1", leds); end
    tick();
    checks++; if (leds !== 3'd2) begin errors++; $display("FAIL pending_leds: got %0d expected 2", leds); end
    checks++; if (zona_lat !== 4'b0100) begin errors++; $display("FAIL pending_zona: got %b expected 0100", zona_lat); end
    ticks(D - 1);
    checks++; if (leds !== 3'd2 || sirena !== 1'b0) begin errors++; $display("FAIL delay_end: got leds=%0d sirena=%b expected 2/0", leds, sirena); end
    tick();
    checks++; if (leds !== 3'd3 || sirena !== 1'b1) begin errors++; $display("FAIL alarm_entry: got leds=%0d sirena=%b expected 3/1", leds, sirena); end
  endtask

  task automatic test_silence();
    silenciar = 1'b1;
    tick();
    checks++; if (leds !== 3'd4 || sirena !== 1'b0) begin errors++; $display("FAIL sil_entry: got leds=%0d sirena=%b expected 4/0", leds, sirena); end
    for (int i = 0; i < S - 1; i++) begin
      tick();
      checks++; if (leds !== 3'd4 || sirena !== 1'b0) begin errors++; $display("FAIL sil_hold i=%0d: got leds=%0d sirena=%b expected 4/0", i, leds, sirena); end
    end
    silenciar = 1'b0;
    tick();
    checks++; if (leds !== 3'd3 || sirena !== 1'b1) begin errors++; $display("FAIL sil_realarm: got leds=%0d sirena=%b expected 3/1", leds, sirena); end
    silenciar = 1'b1; sensores = '0;
    tick();
    silenciar = 1'b0;
    checks++; if (leds !== 3'd4) begin errors++; $display("FAIL sil2_entry: got %0d expected 4", leds); end
    ticks(S - 1);
    checks++; if (leds !== 3'd4) begin errors++; $display("FAIL sil2_hold: got %0d expected 4", leds); end
    tick();
    checks++; if (leds !== 3'd1 || zona_lat !== 4'b0000 || sirena !== 1'b0) begin errors++; $display("FAIL sil_rearm: got leds=%0d zona=%b sirena=%b expected 1/0000/0", leds, zona_lat, sirena); end
  endtask

  task automatic test_mask();
    mascara = 4'b0100; sensores = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (leds !== 3'd1 || zona_lat !== 4'b0000) begin errors++; $display("FAIL masked i=%0d: got leds=%0d zona=%b expected 1/0000", i, leds, zona_lat); end
    end
    sensores = '0;
    ticks(2);
    mascara = '0; sensores = 4'b0100;
    ticks(2);
    checks++; if (leds !== 3'd1) begin errors++; $display("FAIL unmask_wait: got %0d expected 1", leds); end
    tick();
    checks++; if (leds !== 3'd2 || zona_lat !== 4'b0100) begin errors++; $display("FAIL unmask_pending: got leds=%0d zona=%b expected 2/0100", leds, zona_lat); end
  endtask

  task automatic test_disarm_at_zero();
    ticks(D - 1);
    armar = 1'b0; sensores = '0;
    tick();
    checks++; if (leds !== 3'd0 || sirena !== 1'b0 || zona_lat !== 4'b0000) begin errors++; $display("FAIL disarm: got leds=%0d sirena=%b zona=%b expected 0/0/0000", leds, sirena, zona_lat); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (sirena !== 1'b0 || leds !== 3'd0) begin errors++; $display("FAIL disarm_hold i=%0d: got leds=%0d sirena=%b expected 0/0", i, leds, sirena); end
    end
    armar = 1'b1;
    tick();
    checks++; if (leds !== 3'd1) begin errors++; $display("FAIL rearm: got %0d expected 1", leds); end
  endtask

  task automatic test_latch_display();
    bit found;
    sensores = 4'b1000;
    ticks(3);
    checks++; if (leds !== 3'd2 || zona_lat !== 4'b1000) begin errors++; $display("FAIL zone3: got leds=%0d zona=%b expected 2/1000", leds, zona_lat); end
    sensores = 4'b1010;
    ticks(3);
    checks++; if (zona_lat !== 4'b1010) begin errors++; $display("FAIL zone31: got %b expected 1010", zona_lat); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      checks++; if (SSD !== m_ssd) begin errors++; $display("FAIL latch_ssd i=%0d: got %h expected %h", i, SSD, m_ssd); end
      if (SSD[10:7] == 4'b1110) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL digit0_timeout: got no digit 0 expected digit 0 within 20 cycles"); end
    else if (SSD !== {4'b1110, 7'h79}) begin errors++; $display("FAIL digit0: got %h expected %h", SSD, {4'b1110, 7'h79}); end
  endtask

  task automatic test_async_reset();
    bit found;
    found = (leds == 3'd3);
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (leds == 3'd3) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL reach_alarm: got leds=%0d expected 3 within 30 cycles", leds); end
    #2 reset = 1'b1;
    #1;
    checks++; if (leds !== 3'd0 || sirena !== 1'b0 || zona_lat !== 4'b0000) begin errors++; $display("FAIL async_rst: got leds=%0d sirena=%b zona=%b expected 0/0/0000", leds, sirena, zona_lat); end
    checks++; if (SSD !== 11'h7FF) begin errors++; $display("FAIL async_rst_ssd: got %h expected 7ff", SSD); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (sirena !== 1'b0 || leds !== 3'(m_st)) begin errors++; $display("FAIL post_rst i=%0d: got leds=%0d sirena=%b expected %0d/0", i, leds, sirena, m_st); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      armar = ($urandom_range(0, 63) != 0);
      silenciar = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) sensores = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      if ($urandom_range(0, 19) == 0) mascara = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      tick();
      checks++; if (leds !== 3'(m_st)) begin errors++; $display("FAIL rnd_leds i=%0d: got %0d expected %0d", i, leds, m_st); end
      checks++; if (sirena !== m_sir) begin errors++; $display("FAIL rnd_sirena i=%0d: got %b expected %b", i, sirena, m_sir); end
      checks++; if (zona_lat !== m_lat) begin errors++; $display("FAIL rnd_zona i=%0d: got %b expected %b", i, zona_lat, m_lat); end
      checks++; if (SSD !== m_ssd) begin errors++; $display("FAIL rnd_ssd i=%0d: got %h expected %h", i, SSD, m_ssd); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_entry_delay();
    test_silence();
    test_mask();
    test_disarm_at_zero();
    test_latch_display();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alarma_zonas_param.md
Name: alarma_zonas_param

Overview:
Parametrised successor to the 4-sensor alarm FSM and its 7-segment display path, merged into one block. It adds N zones with a per-zone mask, an entry delay, a timed silence that re-arms itself, and latched zone reporting. Its own digit scanner drives the 11-bit SSD bus. It replaces the FSM/display pair inside the top level.

Parameters:
N_SENS, 4, number of sensor zones (1..16)
DELAY_CYC, 8, entry-delay length in clock cycles (1..65535)
SIL_CYC, 16, silence length in clock cycles (1..65535)
SCAN_DIV, 4, clock cycles each display digit is held (1..65535)

Ports:
CLK_ulong  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears every register immediately
armar  in  1  level; 1 = system armed, 0 = disarm (highest priority)
silenciar  in  1  level; silence request
sensores  in  N_SENS  raw zone inputs, asynchronous, 1 = tripped
mascara  in  N_SENS  1 = zone bypassed (ignored)
leds  out  3  state code, registered
sirena  out  1  siren drive, registered
zona_lat  out  N_SENS  latched tripped zones, registered
SSD  out  11  {an[3:0], seg[6:0]}, both active-low; seg order {g,f,e,d,c,b,a}; registered

Behaviour:
- Reset values: state IDLE, leds=3'd0, sirena=0, zona_lat=0, cnt=0, scan index=0, scan divider=0, SSD=11'h7FF.
- sensores passes through a 2-flop synchroniser to give s_sync. act = s_sync & ~mascara. mascara is used unsynchronised.
- State codes on leds: IDLE=0, ARMED=1, PENDING=2, ALARM=3, SILENCED=4.
- Disarm: armar=0 in any non-IDLE state goes to IDLE on the next edge and clears zona_lat, cnt and sirena. This overrides every other event in the same cycle.
- IDLE: armar=1 goes to ARMED. Sensors are ignored.
- ARMED: act≠0 goes to PENDING, sets zona_lat|=act, cnt=DELAY_CYC-1.
- PENDING: zona_lat|=act every cycle. If cnt≠0, cnt decrements. If cnt==0, go to ALARM. PENDING therefore lasts exactly DELAY_CYC cycles.
- ALARM: sirena=1 on the same edge the state becomes ALARM. zona_lat|=act. silenciar=1 goes to SILENCED with cnt=SIL_CYC-1 and sirena=0.
- SILENCED: zona_lat|=act. cnt decrements. When cnt==0:
  - act≠0 goes to ALARM with sirena=1.
  - act==0 goes to ARMED and clears zona_lat.
  - silenciar is ignored in this state and does not extend the silence.
- Latency: a sensor held high before edge k gives s_sync high after edge k+1 and leds=2 after edge k+2.
- Masking a zone after it has latched does not clear its zona_lat bit.
- cnt is 16 bits and saturates at 0. It is never reloaded except on state entry.
- Display scan:
  - The divider counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - an is one-hot low: digit d gives an[d]=0.
  - SSD is registered one cycle after the index changes.
- Digit contents:
  - Digit 0: hex index of the lowest set bit of zona_lat. Blank (seg=7'h7F) if zona_lat==0.
  - Digit 1: state code.
  - Digit 2: cnt[3:0] and digit 3: cnt[7:4], only in PENDING or SILENCED. Otherwise both are blank.
- Hex patterns (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Asynchronous reset mid-alarm forces every reset value at once, with no glitch on sirena after release.

Test Plan:
- Reset, armar=1 for 1 cycle → leds=1. sensores=4'b0100 → leds=2 exactly 3 edges later, zona_lat=4'b0100. 8 cycles later → leds=3, sirena=1.
- mascara=4'b0100, sensores=4'b0100 while ARMED → leds stays 1, zona_lat=0. Unmask → PENDING 3 edges later.
- ALARM, silenciar pulse → leds=4, sirena=0 for 16 cycles. Sensor still high → back to leds=3, sirena=1. Repeat with sensor low → leds=1, zona_lat=0.
- PENDING with armar dropped in the same cycle that cnt reaches 0 → leds=0, sirena never asserts, zona_lat=0.
- Zones 3 then 1 trip during PENDING → zona_lat=4'b1010, digit 0 shows "1" (SSD={4'b1110,7'h79}).
- Display check with SCAN_DIV=4: an cycles 1110,1101,1011,0111 every 4 clocks. In PENDING with cnt=5, digit 2 seg=7'h12. Assert reset mid-scan → SSD=11'h7FF immediately.
